multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multicycle CPU datapath. It sequences the Instruction Register (IRWrite), PC, memory port, register file and ALU through fetch, decode, execute, memory and write-back. It decodes the 6-bit Opcode presented by the Instruction Register, waits on a memory ready handshake, and halts on HALT, illegal opcodes or memory timeout.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles per memory access before fault; 0 disables the timeout; range 0-255.
- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-low reset.
- Opcode  in  6  from Instruction Register Opcode output.
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite, PCWrite, PCWriteCond, BranchNe  out  1 each  PC/IR write controls; BranchNe inverts the zero test.
- PCSrc  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target.
- IorD, MemRead, MemWrite  out  1 each  address select (0=PC, 1=ALUOut) and strobes.
- RegWrite, RegDst, MemToReg  out  1 each  RegDst 1 selects R3, 0 selects R2.
- ALUSrcA  out  1  0=PC, 1=reg A.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-extended Imm, 11 Imm<<2.
- ALUOp  out  4  ALU function.
- Halted, IllegalOp, MemTimeout  out  1 each  sticky status flags.

## Operation
- Opcode classes:
  - 00xxxx: R-type; ALUOp=Opcode[3:0].
  - 01xxxx: I-type; ALUOp=Opcode[3:0].
  - 100000: LW.
  - 100001: SW.
  - 110000: BEQ.
  - 110001: BNE.
  - 110010: J.
  - 111111: HALT.
  - All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT.
- IDLE: all outputs 0 → FETCH.
- FETCH: MemRead=1, IorD=0.
  - On MemReady: IRWrite=1, PCWrite=1, PCSrc=00, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD(0000) → DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (precompute branch target).
  - R/I/LW/SW → EXEC.
  - BEQ/BNE/J → BRANCH.
  - HALT → HALT.
  - Illegal → HALT with IllegalOp=1.
- EXEC: ALUSrcA=1.
  - R: ALUSrcB=00.
  - I: ALUSrcB=10.
  - LW/SW: ALUSrcB=10, ALUOp=ADD.
  - Next: R/I → WB; LW/SW → MEM.
- MEM: IorD=1; MemRead (LW) or MemWrite (SW) held until MemReady.
  - On MemReady: LW → WB, SW → FETCH.
- WB: RegWrite=1.
  - RegDst=1 for R-type only.
  - MemToReg=1 for LW only.
  - Next: FETCH.
- BRANCH:
  - BEQ/BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB(0001), PCWriteCond=1, PCSrc=01; BranchNe=1 for BNE.
  - J: PCWrite=1, PCSrc=10.
  - Next: FETCH.
- HALT: Halted=1; all strobes 0; exits only via reset.
- Memory timeout: a wait counter (8 bits) clears on entry to FETCH/MEM and increments each cycle without MemReady. When it reaches MEM_TIMEOUT with no MemReady, the FSM goes to HALT and sets MemTimeout=1. MemReady arriving in the same cycle as the limit wins.
- Opcode is sampled only in DECODE, EXEC, MEM, WB and BRANCH. It is valid once IRWrite has taken effect.

## Timing
- Reset: Rst low at a rising edge → state IDLE. Every output is 0 in the following cycle, including the status flags. This holds mid-access too; MemReady is ignored while Rst is low.
- Strobes decode from state plus MemReady (Mealy in FETCH/MEM only). The state register and flags are registered.
- Cycles per instruction with MemReady tied high:
  - R/I: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE/J: 3.
  - Each memory wait cycle adds 1.
- After reset release, the first FETCH strobe appears 1 cycle later (IDLE cycle).
- IRWrite and PCWrite are single-cycle pulses per fetch.
- MemRead/MemWrite stay asserted continuously until the MemReady cycle inclusive.

## Structure
- Shared package/header cpu_ctrl_defs holds:
  - state encoding (3 bits);
  - opcode constants (LW, SW, BEQ, BNE, J, HALT) and class masks;
  - ALUOp ADD/SUB;
  - PCSrc and ALUSrcB encodings.
- The same package is used by the datapath and benches.
- One combinational sub-module, opcode_class_decode: maps Opcode to one-hot {rtype, itype, lw, sw, beq, bne, j, halt, illegal}.
- The FSM, wait counter and output decode live in multicycle_controller.

## Test plan
- Reset, MemReady=1, Opcode=000010 (R-type) → IDLE, FETCH (IRWrite=PCWrite=1), DECODE, EXEC (ALUOp=0010, ALUSrcB=00), WB (RegWrite=1, RegDst=1). Next FETCH is at cycle 5.
- LW (100000) with MemReady low for 3 cycles in MEM → MemRead and IorD held for 4 cycles, then WB with MemToReg=1, RegDst=0.
- SW then BNE → SW returns to FETCH after MEM without RegWrite. BNE BRANCH cycle shows PCWriteCond=1, BranchNe=1, PCSrc=01, ALUOp=0001.
- MEM_TIMEOUT=4, MemReady held low in FETCH → MemTimeout=1 and Halted=1 after 4 wait cycles; no IRWrite ever. Rst low then clears all flags.
- Opcode 101010 → HALT with IllegalOp=1. Opcode 111111 → Halted=1, IllegalOp=0; state held for 20 cycles.
- Rst asserted during MEM of SW → MemWrite drops next cycle and all outputs are 0; restart fetch is verified.

Source files
------------

// File: rtl/cpu_ctrl_defs.sv
// Shared encodings for the multicycle CPU control path.
// Used by the controller, the datapath and the benches.
package cpu_ctrl_defs;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_BRANCH = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_J    = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Class masks compare against Opcode[5:4]
  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_SH2 = 2'b11;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic halt;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Opcode/memory handshake in, datapath controls and status out.
// master drives Opcode/MemReady, slave is the controller.
interface multicycle_controller_if;

  logic [5:0] Opcode;
  logic       MemReady;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic       Halted;
  logic       IllegalOp;
  logic       MemTimeout;

  modport master (
    output Opcode, MemReady,
    input  IRWrite, PCWrite, PCWriteCond, BranchNe,
    input  PCSrc, IorD, MemRead, MemWrite,
    input  RegWrite, RegDst, MemToReg,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  Halted, IllegalOp, MemTimeout
  );

  modport slave (
    input  Opcode, MemReady,
    output IRWrite, PCWrite, PCWriteCond, BranchNe,
    output PCSrc, IorD, MemRead, MemWrite,
    output RegWrite, RegDst, MemToReg,
    output ALUSrcA, ALUSrcB, ALUOp,
    output Halted, IllegalOp, MemTimeout
  );

endinterface

// File: rtl/opcode_class_decode.sv
// Maps the 6-bit Opcode onto a one-hot instruction class.
// Anything outside the defined classes is flagged illegal.
module opcode_class_decode
  import cpu_ctrl_defs::*;
(
  input  logic [5:0] op_i,
  output opclass_t   cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (1'b1)
      op_i[5:4] == CLS_R: cls_o.rtype = 1'b1;
      op_i[5:4] == CLS_I: cls_o.itype = 1'b1;
      op_i == OP_LW:      cls_o.lw    = 1'b1;
      op_i == OP_SW:      cls_o.sw    = 1'b1;
      op_i == OP_BEQ:     cls_o.beq   = 1'b1;
      op_i == OP_BNE:     cls_o.bne   = 1'b1;
      op_i == OP_J:       cls_o.j     = 1'b1;
      op_i == OP_HALT:    cls_o.halt  = 1'b1;
      default:            cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with memory wait timeout.
// Strobes are Mealy on MemReady only in FETCH and MEM.
module multicycle_controller
  import cpu_ctrl_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Rst,
  multicycle_controller_if.slave bus
);

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  opclass_t   cls;
  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic       tmo_q, tmo_d;
  logic [7:0] wait_inc;
  logic       in_wait;
  logic       expire;

  opcode_class_decode u_dec (
    .op_i  (bus.Opcode),
    .cls_o (cls)
  );

  assign in_wait  = (state_q == S_FETCH) ||
                    (state_q == S_MEM);
  assign wait_inc = wait_q + 8'd1;
  assign expire   = in_wait && !bus.MemReady &&
                    (TMO_LIM != 8'd0) &&
                    (wait_inc == TMO_LIM);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    wait_d    = (in_wait && !bus.MemReady) ?
                wait_inc : 8'd0;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls.rtype || cls.itype ||
            cls.lw || cls.sw)
          state_d = S_EXEC;
        else if (cls.beq || cls.bne || cls.j)
          state_d = S_BRANCH;
        else if (cls.halt)
          state_d = S_HALT;
        else begin
          state_d   = S_HALT;
          illegal_d = illegal_q | cls.illegal;
        end
      end
      S_EXEC: begin
        state_d = (cls.lw || cls.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.MemReady)
          state_d = cls.lw ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
    endcase
    // A ready in the limit cycle completes normally
    if (expire) begin
      state_d = S_HALT;
      tmo_d   = 1'b1;
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.PCSrc       = PCSRC_SEQ;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_REG;
    bus.ALUOp       = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          bus.PCSrc   = PCSRC_SEQ;
          bus.ALUSrcB = SRCB_4;
          bus.ALUOp   = ALU_ADD;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_SH2;
        bus.ALUOp   = ALU_ADD;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        if (cls.lw || cls.sw) begin
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = ALU_ADD;
        end else if (cls.itype) begin
          bus.ALUSrcB = SRCB_IMM;
          bus.ALUOp   = bus.Opcode[3:0];
        end else begin
          bus.ALUSrcB = SRCB_REG;
          bus.ALUOp   = bus.Opcode[3:0];
        end
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = cls.lw;
        bus.MemWrite = cls.sw;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = cls.rtype;
        bus.MemToReg = cls.lw;
      end
      S_BRANCH: begin
        if (cls.j) begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = PCSRC_J;
        end else begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = SRCB_REG;
          bus.ALUOp       = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSrc       = PCSRC_BR;
          bus.BranchNe    = cls.bne;
        end
      end
      default: ;
    endcase
  end

  assign bus.Halted     = halted_q;
  assign bus.IllegalOp  = illegal_q;
  assign bus.MemTimeout = tmo_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
// One vector per clock; inputs at negedge, outputs checked 1ns later.
module tb_multicycle_controller;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [21:0] IRW  = 22'h1 << 21;
  localparam logic [21:0] PCW  = 22'h1 << 20;
  localparam logic [21:0] PCWC = 22'h1 << 19;
  localparam logic [21:0] BNEF = 22'h1 << 18;
  localparam logic [21:0] PSBR = 22'h1 << 16;
  localparam logic [21:0] PSJ  = 22'h2 << 16;
  localparam logic [21:0] IORD = 22'h1 << 15;
  localparam logic [21:0] MRD  = 22'h1 << 14;
  localparam logic [21:0] MWR  = 22'h1 << 13;
  localparam logic [21:0] RW   = 22'h1 << 12;
  localparam logic [21:0] RD   = 22'h1 << 11;
  localparam logic [21:0] M2R  = 22'h1 << 10;
  localparam logic [21:0] SRCA = 22'h1 << 9;
  localparam logic [21:0] SB4  = 22'h1 << 7;
  localparam logic [21:0] SBI  = 22'h2 << 7;
  localparam logic [21:0] SBS  = 22'h3 << 7;
  localparam logic [21:0] HLT  = 22'h1 << 2;
  localparam logic [21:0] ILL  = 22'h1 << 1;
  localparam logic [21:0] TMO  = 22'h1;

  localparam logic [21:0] FOK = IRW | PCW | MRD | SB4;

  localparam logic [5:0] R_OP  = 6'b000010;
  localparam logic [5:0] I_OP  = 6'b010101;
  localparam logic [5:0] LW_OP = 6'b100000;
  localparam logic [5:0] SW_OP = 6'b100001;
  localparam logic [5:0] BQ_OP = 6'b110000;
  localparam logic [5:0] BN_OP = 6'b110001;
  localparam logic [5:0] J_OP  = 6'b110010;
  localparam logic [5:0] BAD   = 6'b101010;
  localparam logic [5:0] HL_OP = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic        chk;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nrun  = 0;
  int   nfail = 0;

  logic [21:0] act;
  assign act = {bus.IRWrite, bus.PCWrite,
                bus.PCWriteCond, bus.BranchNe,
                bus.PCSrc, bus.IorD,
                bus.MemRead, bus.MemWrite,
                bus.RegWrite, bus.RegDst,
                bus.MemToReg, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp,
                bus.Halted, bus.IllegalOp,
                bus.MemTimeout};

  function automatic logic [21:0] alu(input logic [3:0] a);
    return {18'b0, a} << 3;
  endfunction

  task automatic add(input logic r, input logic [5:0] o,
                     input logic m, input logic c,
                     input logic [21:0] e);
    vec_t v;
    v.rst_n = r;
    v.op    = o;
    v.mr    = m;
    v.chk   = c;
    v.exp   = e;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [5:0] o,
                      input logic m, input logic c,
                      input logic [21:0] e,
                      input string nm);
    @(negedge Clk);
    Rst          = r;
    bus.Opcode   = o;
    bus.MemReady = m;
    #1;
    if (c) begin
      nrun++;
      if (act !== e) begin
        nfail++;
        $display("FAIL %s: got %h expected %h",
                 nm, act, e);
      end
    end
  endtask

  initial begin
    bus.Opcode   = 6'd0;
    bus.MemReady = 1'b0;

    // reset, then R-type
    add(0, R_OP, 1, 0, 0);
    add(0, R_OP, 1, 1, 0);
    add(1, R_OP, 1, 1, 0);
    add(1, R_OP, 1, 1, FOK);
    add(1, R_OP, 1, 1, SBS);
    add(1, R_OP, 1, 1, SRCA | alu(4'h2));
    add(1, R_OP, 1, 1, RW | RD);
    // LW with three wait cycles in MEM
    add(1, LW_OP, 1, 1, FOK);
    add(1, LW_OP, 1, 1, SBS);
    add(1, LW_OP, 1, 1, SRCA | SBI);
    add(1, LW_OP, 0, 1, IORD | MRD);
    add(1, LW_OP, 0, 1, IORD | MRD);
    add(1, LW_OP, 0, 1, IORD | MRD);
    add(1, LW_OP, 1, 1, IORD | MRD);
    add(1, LW_OP, 1, 1, RW | M2R);
    // SW then BNE
    add(1, SW_OP, 1, 1, FOK);
    add(1, SW_OP, 1, 1, SBS);
    add(1, SW_OP, 1, 1, SRCA | SBI);
    add(1, SW_OP, 1, 1, IORD | MWR);
    add(1, BN_OP, 1, 1, FOK);
    add(1, BN_OP, 1, 1, SBS);
    add(1, BN_OP, 1, 1,
        SRCA | alu(4'h1) | PCWC | BNEF | PSBR);
    // J
    add(1, J_OP, 1, 1, FOK);
    add(1, J_OP, 1, 1, SBS);
    add(1, J_OP, 1, 1, PCW | PSJ);
    // I-type
    add(1, I_OP, 1, 1, FOK);
    add(1, I_OP, 1, 1, SBS);
    add(1, I_OP, 1, 1, SRCA | SBI | alu(4'h5));
    add(1, I_OP, 1, 1, RW);
    // BEQ, ready lands exactly on the timeout limit
    add(1, BQ_OP, 0, 1, MRD);
    add(1, BQ_OP, 0, 1, MRD);
    add(1, BQ_OP, 0, 1, MRD);
    add(1, BQ_OP, 1, 1, FOK);
    add(1, BQ_OP, 1, 1, SBS);
    add(1, BQ_OP, 1, 1,
        SRCA | alu(4'h1) | PCWC | PSBR);
    // illegal opcode
    add(1, BAD, 1, 1, FOK);
    add(1, BAD, 1, 1, SBS);
    add(1, BAD, 1, 1, HLT | ILL);
    add(1, BAD, 1, 1, HLT | ILL);
    add(0, BAD, 1, 1, HLT | ILL);
    add(0, BAD, 1, 1, 0);
    add(1, HL_OP, 1, 1, 0);
    // HALT opcode
    add(1, HL_OP, 1, 1, FOK);
    add(1, HL_OP, 1, 1, SBS);
    add(1, HL_OP, 1, 1, HLT);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst_n, tbl[i].op, tbl[i].mr,
           tbl[i].chk, tbl[i].exp,
           $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++)
      step(1, 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), 1, HLT,
           $sformatf("halt_hold%0d", i));

    // fetch timeout: four waits, then halt
    step(0, R_OP, 0, 1, HLT, "to_rst0");
    step(0, R_OP, 0, 1, 0, "to_rst1");
    step(1, R_OP, 0, 1, 0, "to_idle");
    for (int i = 0; i < 4; i++)
      step(1, R_OP, 0, 1, MRD,
           $sformatf("to_wait%0d", i));
    step(1, R_OP, 0, 1, HLT | TMO, "to_halt");
    step(1, R_OP, 1, 1, HLT | TMO, "to_sticky");
    step(0, R_OP, 1, 1, HLT | TMO, "to_rstcyc");
    step(1, SW_OP, 1, 1, 0, "to_clear");

    // reset during a SW memory access
    step(1, SW_OP, 1, 1, FOK, "sw_fetch");
    step(1, SW_OP, 1, 1, SBS, "sw_dec");
    step(1, SW_OP, 1, 1, SRCA | SBI, "sw_exec");
    step(1, SW_OP, 0, 1, IORD | MWR, "sw_mem");
    step(0, SW_OP, 1, 1, IORD | MWR, "sw_rstcyc");
    step(1, SW_OP, 1, 1, 0, "sw_idle");
    step(1, R_OP, 1, 1, FOK, "sw_refetch");
    step(1, R_OP, 1, 1, SBS, "sw_redec");

    $display("[TB] %0d tests run, %0d failed",
             nrun, nfail);
    $finish;
  end

endmodule
